// File: rtl/squash_io_pkg.sv
// Shared definitions for the squash I/O controller: FSM state encodings and
// default debounce / reset-hold lengths.
package squash_io_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int RESET_HOLD_DEF      = 16;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_ENABLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/squash_debounce.sv
// One button path: 2-flop synchroniser followed by a counter that accepts a
// level change only after DEBOUNCE_CYCLES consecutive differing samples.
module squash_debounce
    import squash_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic stable_n
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_n;
    logic          sync_n;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_n   <= 1'b1;
            sync_n   <= 1'b1;
            cnt      <= '0;
            stable_n <= 1'b1;
        end else begin
            meta_n <= raw_n;
            sync_n <= meta_n;
            if (sync_n == stable_n) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable_n <= sync_n;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/squash_io_ctrl.sv
// Pad-side controller for the squash game: reset sequencing FSM driving the
// core reset and pad output enable, plus four debounced buttons.
module squash_io_ctrl
    import squash_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RESET_HOLD      = RESET_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_reset_n,
    input  logic       pause_n_raw,
    input  logic       new_game_n_raw,
    input  logic       down_key_n_raw,
    input  logic       up_key_n_raw,
    output logic       game_reset,
    output logic       pause_n,
    output logic       new_game_n,
    output logic       down_key_n,
    output logic       up_key_n,
    output logic       oeb,
    output logic [1:0] state
);

    localparam int             HW       = $clog2(RESET_HOLD);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(RESET_HOLD - 1);

    logic          ext_meta_n;
    logic          ext_sync_n;
    logic          trigger;
    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_d;
    logic [3:0]    btn_raw_n;
    logic [3:0]    btn_db_n;
    logic          run;

    assign trigger = reset | ~ext_sync_n;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt;
        if (trigger) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_MAX) begin
                        state_d    = ST_ENABLE;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt + 1'b1;
                    end
                end
                ST_ENABLE: state_d = ST_RUN;
                ST_RUN:    state_d = ST_RUN;
                default: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they move with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_meta_n <= 1'b1;
            ext_sync_n <= 1'b1;
            state_q    <= ST_HOLD;
            hold_cnt   <= '0;
            game_reset <= 1'b1;
            oeb        <= 1'b1;
        end else begin
            ext_meta_n <= ext_reset_n;
            ext_sync_n <= ext_meta_n;
            state_q    <= state_d;
            hold_cnt   <= hold_cnt_d;
            game_reset <= (state_d != ST_RUN);
            oeb        <= (state_d == ST_HOLD);
        end
    end

    assign state     = state_q;
    assign btn_raw_n = {up_key_n_raw, down_key_n_raw, new_game_n_raw, pause_n_raw};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        squash_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .raw_n   (btn_raw_n[i]),
            .stable_n(btn_db_n[i])
        );
    end

    // Buttons read as released until the core is actually running.
    assign run        = (state_q == ST_RUN);
    assign pause_n    = btn_db_n[0] | ~run;
    assign new_game_n = btn_db_n[1] | ~run;
    assign down_key_n = btn_db_n[2] | ~run;
    assign up_key_n   = btn_db_n[3] | ~run;

endmodule

// File: tb/tb_squash_io_ctrl.sv
// Self-checking bench for squash_io_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a sample-history reference model.
module tb_squash_io_ctrl;

    localparam int DC = 4;
    localparam int RH = 8;

    logic       clk = 1'b0;
    logic       reset, ext_reset_n;
    logic       pause_n_raw, new_game_n_raw, down_key_n_raw, up_key_n_raw;
    logic       game_reset, pause_n, new_game_n, down_key_n, up_key_n, oeb;
    logic [1:0] state;

    squash_io_ctrl #(.DEBOUNCE_CYCLES(DC), .RESET_HOLD(RH)) dut (
        .clk           (clk),
        .reset         (reset),
        .ext_reset_n   (ext_reset_n),
        .pause_n_raw   (pause_n_raw),
        .new_game_n_raw(new_game_n_raw),
        .down_key_n_raw(down_key_n_raw),
        .up_key_n_raw  (up_key_n_raw),
        .game_reset    (game_reset),
        .pause_n       (pause_n),
        .new_game_n    (new_game_n),
        .down_key_n    (down_key_n),
        .up_key_n      (up_key_n),
        .oeb           (oeb),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw input history per edge {ext, up, down, new, pause};
    // a synchronised value seen at edge e is the raw sample from edge e-2.
    logic [4:0] hist [0:8191];
    int         e        = -1;
    int         rst_edge = 0;
    int         tf       = 0;     // consecutive trigger-free edges
    logic [3:0] mo       = 4'hF;  // debounced levels
    int         exp_st   = 0;

    function automatic logic s_at(input int ed, input int b);
        return (ed - 2 > rst_edge) ? hist[ed-2][b] : 1'b1;
    endfunction

    task automatic model_edge();
        logic all_diff;
        e++;
        hist[e] = {ext_reset_n, up_key_n_raw, down_key_n_raw, new_game_n_raw, pause_n_raw};
        if (reset) begin
            rst_edge = e;
            mo       = 4'hF;
            tf       = 0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (e - rst_edge >= DC) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DC; k++)
                        if (s_at(e - k, b) == mo[b]) all_diff = 1'b0;
                    if (all_diff) mo[b] = ~mo[b];
                end
            end
            if (!s_at(e, 4)) tf = 0;
            else if (tf <= RH) tf++;
        end
        exp_st = (tf < RH) ? 0 : (tf == RH) ? 1 : 2;
    endtask

    task automatic step();
        logic [3:0] exp_btn;
        model_edge();
        @(posedge clk);
        #1;
        exp_btn = (exp_st == 2) ? mo : 4'hF;
        check("state", 32'(state), 32'(exp_st));
        check("game_reset", 32'(game_reset), 32'(exp_st != 2));
        check("oeb", 32'(oeb), 32'(exp_st == 0));
        check("buttons", 32'({up_key_n, down_key_n, new_game_n, pause_n}), 32'(exp_btn));
    endtask

    int hold_left [4];
    logic [3:0] btn;

    initial begin
        reset = 1'b1; ext_reset_n = 1'b1;
        pause_n_raw = 1'b1; new_game_n_raw = 1'b1; down_key_n_raw = 1'b1; up_key_n_raw = 1'b1;

        // Power-up: one reset cycle, then eight HOLD cycles before the pads enable
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_oeb", 32'(oeb), 32'd1);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check("pwr_oeb", 32'(oeb), (i < 8) ? 32'd1 : 32'd0);
            check("pwr_game_reset", 32'(game_reset), 32'd1);
            check("pwr_buttons", 32'({up_key_n, down_key_n, new_game_n, pause_n}), 32'hF);
        end
        step();
        check("pwr_run_game_reset", 32'(game_reset), 32'd0);
        check("pwr_run_state", 32'(state), 32'd2);

        // Held press: visible exactly five edges after the first sampling edge
        up_key_n_raw = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            step();
            check("up_latency", 32'(up_key_n), (k == 5) ? 32'd0 : 32'd1);
            check("up_others", 32'({down_key_n, new_game_n, pause_n}), 32'h7);
        end
        up_key_n_raw = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("up_release", 32'(up_key_n), 32'd1);

        // Three-cycle glitch must be rejected
        down_key_n_raw = 1'b0;
        for (int k = 0; k < 3; k++) step();
        down_key_n_raw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("glitch_down", 32'(down_key_n), 32'd1);
        end

        // Trigger re-asserted at hold count 5 restarts the full hold
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 0; k < 3; k++) step();
        ext_reset_n = 1'b0; step();
        ext_reset_n = 1'b1; step();
        step();
        check("retrig_state", 32'(state), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step();
            check("retrig_oeb", 32'(oeb), (i < 8) ? 32'd1 : 32'd0);
        end
        step();
        check("retrig_run", 32'(state), 32'd2);

        // External reset in RUN with a button pressed
        pause_n_raw = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("ext_pre_pause", 32'(pause_n), 32'd0);
        ext_reset_n = 1'b0;
        step();
        step();
        check("ext_n1_state", 32'(state), 32'd2);
        step();
        check("ext_state", 32'(state), 32'd0);
        check("ext_game_reset", 32'(game_reset), 32'd1);
        check("ext_oeb", 32'(oeb), 32'd1);
        check("ext_buttons", 32'({up_key_n, down_key_n, new_game_n, pause_n}), 32'hF);
        ext_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Pause held across a reset pulse: reappears once back in RUN
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 8) check("hold_pause_enable", 32'(pause_n), 32'd1);
        end
        check("hold_pause_state", 32'(state), 32'd2);
        check("hold_pause_val", 32'(pause_n), 32'd0);
        pause_n_raw = 1'b1;

        // Randomized traffic with occasional external and core resets
        for (int b = 0; b < 4; b++) hold_left[b] = 0;
        btn = 4'hF;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold_left[b] == 0) begin
                    btn[b]       = 1'($urandom_range(0, 1));
                    hold_left[b] = $urandom_range(1, 9);
                end else begin
                    hold_left[b]--;
                end
            end
            {up_key_n_raw, down_key_n_raw, new_game_n_raw, pause_n_raw} = btn;
            ext_reset_n = ($urandom_range(0, 149) != 0);
            reset       = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
